hazard_forward_unit: RTL and testbench

Parametrised data-hazard unit for the in-order integer pipeline. It sits beside the decode stage and tracks in-flight destination registers across `FWD_DEPTH` downstream stages. It selects a forwarded value for each of `NUM_SRC` source operands, stalls fetch/decode on load-use hazards, and optionally holds execute for multi-cycle multiply/divide. It supersedes the fixed two-stage, two-operand hazard logic.

---
 rtl/hazard_pkg.sv | 26 ++
 rtl/hazard_operand_sel.sv | 61 ++++++
 rtl/hazard_forward_unit.sv | 158 +++++++++++++++
 tb/tb_hazard_forward_unit.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the data-hazard / forwarding unit.
//   sb_entry_t : scoreboard entry tracking one in-flight instruction
//   fwd_src_e  : where a resolved decode operand comes from
//   REG_ZERO   : hard-wired zero register index (never forwarded)
package hazard_pkg;

  // Entry rd field is sized for the widest register index in use; narrower
  // indices are zero-extended on entry and on compare.
  localparam int unsigned SB_RD_W  = 8;
  localparam int unsigned REG_ZERO = 0;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               rd_we;
    logic               is_load;
    logic               is_muldiv;
  } sb_entry_t;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_DM,
    FWD_STAGE
  } fwd_src_e;

endpackage

// File: rtl/hazard_operand_sel.sv
// hazard_operand_sel: priority match of one decode source operand against
// the scoreboard. The youngest matching entry wins.
//   i_rs / i_rs_used : source register index and its use flag
//   i_sb             : scoreboard entries 1..FWD_DEPTH (1 = execute)
//   i_skip_e1        : ignore entry 1 (execute frozen by a mul/div)
//   o_src / o_idx    : forwarding source and matching stage number
//   o_stall_req      : operand depends on a load not yet at LOAD_STAGE
module hazard_operand_sel
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned FWD_DEPTH  = 2,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned IDX_W      = 2
) (
  input  logic [REG_ADDR_W-1:0]   i_rs,
  input  logic                    i_rs_used,
  input  sb_entry_t [FWD_DEPTH:1] i_sb,
  input  logic                    i_skip_e1,
  output fwd_src_e                o_src,
  output logic [IDX_W-1:0]        o_idx,
  output logic                    o_stall_req
);

  logic w_unused_md;

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    o_src       = FWD_RF;
    o_idx       = '0;
    o_stall_req = 1'b0;
    for (int unsigned k = FWD_DEPTH; k >= 1; k--) begin
      if (i_rs_used && (i_rs != REG_ADDR_W'(REG_ZERO)) &&
          !(i_skip_e1 && (k == 1)) &&
          i_sb[k].valid && i_sb[k].rd_we &&
          (i_sb[k].rd == SB_RD_W'(i_rs))) begin
        if (i_sb[k].is_load && (k < LOAD_STAGE)) begin
          o_src       = FWD_RF;
          o_idx       = '0;
          o_stall_req = 1'b1;
        end else if (i_sb[k].is_load && (k == LOAD_STAGE)) begin
          o_src       = FWD_DM;
          o_idx       = IDX_W'(k);
          o_stall_req = 1'b0;
        end else begin
          o_src       = FWD_STAGE;
          o_idx       = IDX_W'(k);
          o_stall_req = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_unused_md = 1'b0;
    for (int unsigned k = 1; k <= FWD_DEPTH; k++) begin
      w_unused_md = w_unused_md ^ i_sb[k].is_muldiv;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: data-hazard unit beside decode. Tracks destination
// registers of FWD_DEPTH downstream stages, forwards operands, stalls
// fetch/decode on load-use, and (optionally) freezes execute for mul/div.
// Optional feature macro: HAZARD_MULDIV_STALL_EN (mul/div busy counter).
// Ports:
//   clk, rst (sync, active-high)
//   dec_*          : decode-stage instruction info and register-file operands
//   stage_result   : result in stage k at slice k-1
//   dm_read_data   : load data at LOAD_STAGE
//   flush          : taken branch/jump resolved in execute
//   operand_out, fwd_hit : resolved operands and per-operand forward flags
//   *_enable_ff, d_to_e_bubble : pipeline register controls
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned FWD_DEPTH  = 2,
  parameter int unsigned LOAD_STAGE = 2,
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          dec_valid,
  input  logic [REG_ADDR_W-1:0]         dec_rd,
  input  logic                          dec_rd_we,
  input  logic                          dec_is_load,
  input  logic                          dec_is_muldiv,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] dec_rs,
  input  logic [NUM_SRC-1:0]            dec_rs_used,
  input  logic [NUM_SRC*XLEN-1:0]       dec_operand,
  input  logic [FWD_DEPTH*XLEN-1:0]     stage_result,
  input  logic [XLEN-1:0]               dm_read_data,
  input  logic                          flush,
  output logic [NUM_SRC*XLEN-1:0]       operand_out,
  output logic [NUM_SRC-1:0]            fwd_hit,
  output logic                          f_to_d_enable_ff,
  output logic                          d_to_e_enable_ff,
  output logic                          e_to_m_enable_ff,
  output logic                          d_to_e_bubble
);

  localparam int unsigned IDX_W = $clog2(FWD_DEPTH + 1);

  sb_entry_t [FWD_DEPTH:1] r_sb;
  sb_entry_t               w_new_e1;
  fwd_src_e                w_src [NUM_SRC];
  logic [IDX_W-1:0]        w_idx [NUM_SRC];
  logic [NUM_SRC-1:0]      w_stall_req;
  logic                    w_busy;
  logic                    w_load_use;

`ifdef HAZARD_MULDIV_STALL_EN
  localparam int unsigned MD_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
  logic [MD_W-1:0] r_mdcnt;
  assign w_busy           = (r_mdcnt != '0);
  assign e_to_m_enable_ff = ~w_busy;
`else
  localparam int unsigned W_UNUSED_MD_LAT = MULDIV_LAT;
  assign w_busy           = 1'b0;
  assign e_to_m_enable_ff = 1'b1;
`endif

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_sel
    hazard_operand_sel #(
      .REG_ADDR_W (REG_ADDR_W),
      .FWD_DEPTH  (FWD_DEPTH),
      .LOAD_STAGE (LOAD_STAGE),
      .IDX_W      (IDX_W)
    ) u_sel (
      .i_rs        (dec_rs[i*REG_ADDR_W +: REG_ADDR_W]),
      .i_rs_used   (dec_rs_used[i]),
      .i_sb        (r_sb),
      .i_skip_e1   (w_busy),
      .o_src       (w_src[i]),
      .o_idx       (w_idx[i]),
      .o_stall_req (w_stall_req[i])
    );
  end

  always_comb begin
    operand_out = dec_operand;
    fwd_hit     = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      case (w_src[i])
        FWD_DM: begin
          operand_out[i*XLEN +: XLEN] = dm_read_data;
          fwd_hit[i]                  = 1'b1;
        end
        FWD_STAGE: begin
          fwd_hit[i] = 1'b1;
          for (int unsigned k = 1; k <= FWD_DEPTH; k++) begin
            if (w_idx[i] == IDX_W'(k)) begin
              operand_out[i*XLEN +: XLEN] = stage_result[(k-1)*XLEN +: XLEN];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign w_load_use = dec_valid & (|w_stall_req);

  // Busy freeze dominates; flush turns a load-use stall into a plain bubble.
  always_comb begin
    if (w_busy) begin
      f_to_d_enable_ff = 1'b0;
      d_to_e_enable_ff = 1'b0;
      d_to_e_bubble    = 1'b0;
    end else begin
      f_to_d_enable_ff = ~w_load_use | flush;
      d_to_e_enable_ff = 1'b1;
      d_to_e_bubble    = w_load_use | flush;
    end
  end

  always_comb begin
    w_new_e1 = '0;
    if (dec_valid && !d_to_e_bubble) begin
      w_new_e1.valid     = 1'b1;
      w_new_e1.rd        = SB_RD_W'(dec_rd);
      w_new_e1.rd_we     = dec_rd_we;
      w_new_e1.is_load   = dec_is_load;
      w_new_e1.is_muldiv = dec_is_muldiv;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb <= '0;
`ifdef HAZARD_MULDIV_STALL_EN
      r_mdcnt <= '0;
`endif
    end else if (w_busy) begin
      // Execute holds its mul/div; memory gets a hole, older stages drain.
      for (int unsigned k = FWD_DEPTH; k >= 3; k--) begin
        r_sb[k] <= r_sb[k-1];
      end
      r_sb[2] <= '0;
`ifdef HAZARD_MULDIV_STALL_EN
      r_mdcnt <= r_mdcnt - MD_W'(1);
`endif
    end else begin
      for (int unsigned k = FWD_DEPTH; k >= 2; k--) begin
        r_sb[k] <= r_sb[k-1];
      end
      r_sb[1] <= w_new_e1;
`ifdef HAZARD_MULDIV_STALL_EN
      if (w_new_e1.valid && w_new_e1.is_muldiv) begin
        r_mdcnt <= MD_W'(MULDIV_LAT - 1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  localparam int unsigned XLEN = 64;
  localparam int unsigned RW   = 5;
  localparam int unsigned NS   = 2;
  localparam int unsigned FD   = 3;
  localparam int unsigned LS   = 2;
  localparam int unsigned ML   = 4;
`ifdef HAZARD_MULDIV_STALL_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  localparam logic [63:0] A0 = 64'h0000_0000_0000_00A0;
  localparam logic [63:0] B0 = 64'h0000_0000_0000_00B0;
  localparam logic [63:0] S1 = 64'h1111_0000_0000_0001;
  localparam logic [63:0] S2 = 64'h2222_0000_0000_0002;
  localparam logic [63:0] S3 = 64'h3333_0000_0000_0003;
  localparam logic [63:0] DM = 64'h0000_0000_0000_DEAD;
  localparam logic [63:0] XX = 64'h0;

  logic               clk;
  logic               rst;
  logic               dec_valid;
  logic [RW-1:0]      dec_rd;
  logic               dec_rd_we;
  logic               dec_is_load;
  logic               dec_is_muldiv;
  logic [NS*RW-1:0]   dec_rs;
  logic [NS-1:0]      dec_rs_used;
  logic [NS*XLEN-1:0] dec_operand;
  logic [FD*XLEN-1:0] stage_result;
  logic [XLEN-1:0]    dm_read_data;
  logic               flush;
  logic [NS*XLEN-1:0] operand_out;
  logic [NS-1:0]      fwd_hit;
  logic               f_to_d_enable_ff;
  logic               d_to_e_enable_ff;
  logic               e_to_m_enable_ff;
  logic               d_to_e_bubble;

  int n_pass  = 0;
  int n_total = 0;

  hazard_forward_unit #(
    .XLEN       (XLEN),
    .REG_ADDR_W (RW),
    .NUM_SRC    (NS),
    .FWD_DEPTH  (FD),
    .LOAD_STAGE (LS),
    .MULDIV_LAT (ML)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .dec_valid        (dec_valid),
    .dec_rd           (dec_rd),
    .dec_rd_we        (dec_rd_we),
    .dec_is_load      (dec_is_load),
    .dec_is_muldiv    (dec_is_muldiv),
    .dec_rs           (dec_rs),
    .dec_rs_used      (dec_rs_used),
    .dec_operand      (dec_operand),
    .stage_result     (stage_result),
    .dm_read_data     (dm_read_data),
    .flush            (flush),
    .operand_out      (operand_out),
    .fwd_hit          (fwd_hit),
    .f_to_d_enable_ff (f_to_d_enable_ff),
    .d_to_e_enable_ff (d_to_e_enable_ff),
    .e_to_m_enable_ff (e_to_m_enable_ff),
    .d_to_e_bubble    (d_to_e_bubble)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  // {f2d, d2e, e2m, bubble}
  task automatic chk_ctrl(input string name, input logic [3:0] exp);
    chk(name, {60'h0, f_to_d_enable_ff, d_to_e_enable_ff, e_to_m_enable_ff, d_to_e_bubble}, {60'h0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic v, input int rd, input logic we, input logic ld,
                         input logic md, input int rs0, input int rs1,
                         input logic [1:0] used, input logic fl);
    dec_valid     = v;
    dec_rd        = RW'(rd);
    dec_rd_we     = we;
    dec_is_load   = ld;
    dec_is_muldiv = md;
    dec_rs        = {RW'(rs1), RW'(rs0)};
    dec_rs_used   = used;
    flush         = fl;
  endtask

  task automatic fixed_data();
    dec_operand  = {B0, A0};
    stage_result = {S3, S2, S1};
    dm_read_data = DM;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_dec(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic        v;
    int          rd;
    logic        we, ld, fl;
    int          rs0, rs1;
    logic [1:0]  used;
    logic [63:0] x0, x1;
    logic [1:0]  hit, care;
    logic        f2d, bub;
  } vec_t;

  function automatic vec_t mk(input logic v, input int rd, input logic we, input logic ld,
                              input logic fl, input int rs0, input int rs1, input logic [1:0] used,
                              input logic [63:0] x0, input logic [63:0] x1, input logic [1:0] hit,
                              input logic [1:0] care, input logic f2d, input logic bub);
    vec_t r;
    r.v = v; r.rd = rd; r.we = we; r.ld = ld; r.fl = fl; r.rs0 = rs0; r.rs1 = rs1;
    r.used = used; r.x0 = x0; r.x1 = x1; r.hit = hit; r.care = care; r.f2d = f2d; r.bub = bub;
    return r;
  endfunction

  vec_t tbl [19];

  // ---------------- reference model ----------------
  typedef struct {
    bit          v;
    int unsigned rd;
    bit          we, ld, md;
  } ment_t;

  ment_t       m_pipe [FD+1];
  int unsigned m_mdcnt;

  task automatic model_clear();
    for (int unsigned k = 0; k <= FD; k++) m_pipe[k] = '{0, 0, 0, 0, 0};
    m_mdcnt = 0;
  endtask

  task automatic model_eval(output logic [NS*XLEN-1:0] e_op, output logic [NS-1:0] e_hit,
                            output logic [NS-1:0] e_care, output logic [3:0] e_ctrl,
                            output bit e_busy, output bit e_bub);
    bit any_stall = 0;
    bit lu;
    e_busy = MD_EN && (m_mdcnt != 0);
    e_op   = dec_operand;
    e_hit  = '0;
    e_care = '1;
    for (int unsigned i = 0; i < NS; i++) begin
      int unsigned rs = dec_rs[i*RW +: RW];
      int unsigned found = 0;
      if (dec_rs_used[i] && rs != 0) begin
        for (int unsigned k = 1; k <= FD; k++) begin
          if (found == 0 && !(e_busy && k == 1) && m_pipe[k].v && m_pipe[k].we && m_pipe[k].rd == rs)
            found = k;
        end
      end
      if (found != 0) begin
        if (m_pipe[found].ld && found < LS) begin
          any_stall = 1;
          e_care[i] = 1'b0;
        end else if (m_pipe[found].ld && found == LS) begin
          e_op[i*XLEN +: XLEN] = dm_read_data;
          e_hit[i] = 1'b1;
        end else begin
          e_op[i*XLEN +: XLEN] = stage_result[(found-1)*XLEN +: XLEN];
          e_hit[i] = 1'b1;
        end
      end
    end
    lu = dec_valid && any_stall;
    if (e_busy) begin
      e_ctrl = 4'b0000;
      e_bub  = 0;
    end else begin
      e_bub  = lu || flush;
      e_ctrl = {(!lu || flush), 1'b1, 1'b1, e_bub};
    end
  endtask

  task automatic model_step(input bit busy, input bit bub);
    if (rst) begin
      model_clear();
    end else if (busy) begin
      for (int unsigned k = FD; k >= 3; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[2] = '{0, 0, 0, 0, 0};
      m_mdcnt--;
    end else begin
      for (int unsigned k = FD; k >= 2; k--) m_pipe[k] = m_pipe[k-1];
      if (dec_valid && !bub) begin
        m_pipe[1] = '{1, dec_rd, dec_rd_we, dec_is_load, dec_is_muldiv};
        if (MD_EN && dec_is_muldiv) m_mdcnt = ML - 1;
      end else begin
        m_pipe[1] = '{0, 0, 0, 0, 0};
      end
    end
  endtask

  initial begin
    //            v  rd we ld fl rs0 rs1 used    x0  x1  hit    care  f2d bub
    tbl[0]  = mk(0,  0, 0, 0, 0,  0,  0, 2'b00, A0, B0, 2'b00, 2'b11, 1, 0);
    tbl[1]  = mk(1,  5, 1, 0, 0,  1,  2, 2'b11, A0, B0, 2'b00, 2'b11, 1, 0);
    tbl[2]  = mk(1,  6, 1, 0, 0,  5,  7, 2'b11, S1, B0, 2'b01, 2'b11, 1, 0);
    tbl[3]  = mk(1,  9, 1, 1, 0,  5,  0, 2'b01, S2, B0, 2'b01, 2'b11, 1, 0);
    tbl[4]  = mk(1, 10, 1, 0, 0,  9,  5, 2'b11, XX, S3, 2'b10, 2'b10, 0, 1);
    tbl[5]  = mk(1, 10, 1, 0, 0,  9,  5, 2'b11, DM, B0, 2'b01, 2'b11, 1, 0);
    tbl[6]  = mk(1,  0, 1, 0, 0,  0, 10, 2'b01, A0, B0, 2'b00, 2'b11, 1, 0);
    tbl[7]  = mk(1,  5, 1, 0, 0,  0,  3, 2'b11, A0, B0, 2'b00, 2'b11, 1, 0);
    tbl[8]  = mk(1,  5, 1, 0, 0, 10, 11, 2'b11, S3, B0, 2'b01, 2'b11, 1, 0);
    tbl[9]  = mk(0,  0, 0, 0, 0,  7,  5, 2'b11, A0, S1, 2'b10, 2'b11, 1, 0);
    tbl[10] = mk(0,  0, 0, 0, 0,  5,  5, 2'b11, S2, S2, 2'b11, 2'b11, 1, 0);
    tbl[11] = mk(0,  0, 0, 0, 0,  5,  0, 2'b01, S3, B0, 2'b01, 2'b11, 1, 0);
    tbl[12] = mk(1,  4, 1, 1, 0,  0,  0, 2'b00, A0, B0, 2'b00, 2'b11, 1, 0);
    tbl[13] = mk(0,  0, 0, 0, 0,  4,  0, 2'b01, XX, B0, 2'b00, 2'b10, 1, 0);
    tbl[14] = mk(0,  0, 0, 0, 0,  4,  0, 2'b01, DM, B0, 2'b01, 2'b11, 1, 0);
    tbl[15] = mk(0,  0, 0, 0, 0,  4,  0, 2'b01, S3, B0, 2'b01, 2'b11, 1, 0);
    tbl[16] = mk(1,  9, 1, 1, 0,  0,  0, 2'b00, A0, B0, 2'b00, 2'b11, 1, 0);
    tbl[17] = mk(1, 11, 1, 0, 1,  9,  0, 2'b01, XX, B0, 2'b00, 2'b10, 1, 1);
    tbl[18] = mk(0,  0, 0, 0, 0,  9, 11, 2'b11, DM, B0, 2'b01, 2'b11, 1, 0);

    fixed_data();
    do_reset();

    for (int t = 0; t < 19; t++) begin
      set_dec(tbl[t].v, tbl[t].rd, tbl[t].we, tbl[t].ld, 1'b0,
              tbl[t].rs0, tbl[t].rs1, tbl[t].used, tbl[t].fl);
      @(negedge clk);
      if (tbl[t].care[0]) chk($sformatf("tbl%0d op0", t), operand_out[0 +: XLEN], tbl[t].x0);
      if (tbl[t].care[1]) chk($sformatf("tbl%0d op1", t), operand_out[XLEN +: XLEN], tbl[t].x1);
      chk($sformatf("tbl%0d hit", t), {62'h0, fwd_hit}, {62'h0, tbl[t].hit});
      chk_ctrl($sformatf("tbl%0d ctrl", t), {tbl[t].f2d, 1'b1, 1'b1, tbl[t].bub});
      tick();
    end

    // mul x8 followed by dependent add
    do_reset();
    set_dec(1, 8, 1, 0, 1, 0, 0, 2'b00, 0);
    @(negedge clk);
    chk_ctrl("mul issue ctrl", 4'b1110);
    tick();
    set_dec(1, 6, 1, 0, 0, 8, 0, 2'b01, 0);
    if (MD_EN) begin
      for (int c = 0; c < ML - 1; c++) begin
        @(negedge clk);
        chk_ctrl($sformatf("mul busy%0d ctrl", c), 4'b0000);
        chk($sformatf("mul busy%0d hit", c), {62'h0, fwd_hit}, 64'h0);
        tick();
      end
    end
    @(negedge clk);
    chk_ctrl("mul done ctrl", 4'b1110);
    chk("mul done op0", operand_out[0 +: XLEN], S1);
    chk("mul done hit", {62'h0, fwd_hit}, 64'h1);
    tick();

    // rst asserted while execute is frozen
    do_reset();
    set_dec(1, 8, 1, 0, 1, 0, 0, 2'b00, 0);
    tick();
    set_dec(1, 6, 1, 0, 0, 8, 0, 2'b01, 0);
    @(negedge clk);
    chk_ctrl("busy before rst", MD_EN ? 4'b0000 : 4'b1110);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_ctrl("after rst busy ctrl", 4'b1110);
    chk("after rst busy hit", {62'h0, fwd_hit}, 64'h0);
    chk("after rst busy op0", operand_out[0 +: XLEN], A0);
    tick();

    // rst asserted during a load-use stall
    do_reset();
    set_dec(1, 5, 1, 1, 0, 0, 0, 2'b00, 0);
    tick();
    set_dec(1, 6, 1, 0, 0, 5, 0, 2'b01, 0);
    rst = 1'b1;
    @(negedge clk);
    chk_ctrl("stall before rst", 4'b0111);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_ctrl("after rst stall ctrl", 4'b1110);
    chk("after rst stall hit", {62'h0, fwd_hit}, 64'h0);
    tick();

    // randomized traffic against the reference model
    do_reset();
    model_clear();
    for (int n = 0; n < 1500; n++) begin
      logic [NS*XLEN-1:0] e_op;
      logic [NS-1:0]      e_hit, e_care;
      logic [3:0]         e_ctrl;
      bit                 e_busy, e_bub;
      rst = ($urandom_range(0, 49) == 0);
      set_dec($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 4) != 0,
              $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 7), $urandom_range(0, 7), 2'($urandom_range(0, 3)),
              $urandom_range(0, 9) == 0);
      dec_operand  = {$urandom, $urandom, $urandom, $urandom};
      stage_result = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      dm_read_data = {$urandom, $urandom};
      model_eval(e_op, e_hit, e_care, e_ctrl, e_busy, e_bub);
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
        if (e_care[i]) chk($sformatf("rnd%0d op%0d", n, i), operand_out[i*XLEN +: XLEN], e_op[i*XLEN +: XLEN]);
      end
      chk($sformatf("rnd%0d hit", n), {62'h0, fwd_hit}, {62'h0, e_hit});
      chk_ctrl($sformatf("rnd%0d ctrl", n), e_ctrl);
      @(posedge clk);
      model_step(e_busy, e_bub);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
